// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size and FSM encodings,
// lane geometry, and alignment / lane-mask helpers.
package load_store_unit_pkg;

  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        uns;
    logic [63:0] addr;
  } lsu_req_t;

  function automatic logic misaligned(size_e sz, logic [2:0] off);
    logic m;
    case (sz)
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      SZ_D:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Byte lanes touched by an access of the given size starting at lane off.
  function automatic logic [NUM_LANES-1:0] lane_mask(size_e sz, logic [2:0] off);
    logic [NUM_LANES-1:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the Data_Memory initiator port.
// slave = the load/store unit, master = pipeline and memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic [31:0] stat_ld;
  logic [31:0] stat_st;
  logic [31:0] stat_err;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output MemRead, MemWrite, addr, write_data,
    output stat_ld, stat_st, stat_err
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  MemRead, MemWrite, addr, write_data,
    input  stat_ld, stat_st, stat_err
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane datapath: load extract + sign/zero extend, and
// store merge of right-justified data into a sampled doubleword.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [NUM_LANES-1:0][VEC_W-1:0] rdata,
  input  size_e                           size,
  input  logic                            is_unsigned,
  input  logic [2:0]                      offset,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] wdata,
  output logic [63:0]                     ld_data,
  output logic [NUM_LANES-1:0][VEC_W-1:0] st_data
);

  logic [5:0]                      sh;
  logic [63:0]                     shifted;
  logic [NUM_LANES-1:0][VEC_W-1:0] wshift;
  logic [NUM_LANES-1:0]            mask;

  assign sh      = {offset, 3'b000};
  assign shifted = rdata >> sh;
  assign wshift  = wdata << sh;
  assign mask    = lane_mask(size, offset);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_data[i] = mask[i] ? wshift[i] : rdata[i];
  end

  always_comb begin
    ld_data = shifted;
    case (size)
      SZ_B:    ld_data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
      SZ_H:    ld_data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_W:    ld_data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, doubleword memory access with RMW
// for narrow stores. Define LSU_STATS_EN to build the saturating stat counters.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  localparam int CW = $clog2(RD_LAT + 2);

  state_e        state_q, state_d;
  lsu_req_t      req_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   rdata_q, wdata_q;
  logic          err_q;
  logic          accept, mis, rd_last;
  logic [63:0]   ld_ext, st_merge;

  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign mis     = misaligned(size_e'(bus.req_size), bus.req_addr[2:0]);
  assign rd_last = (state_q == ST_RD) && (cnt_q == CW'(RD_LAT));

  lsu_lane_align u_align (
    .rdata       (bus.read_data),
    .size        (req_q.size),
    .is_unsigned (req_q.uns),
    .offset      (req_q.addr[2:0]),
    .wdata       (wdata_q),
    .ld_data     (ld_ext),
    .st_data     (st_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q   <= '{write: bus.req_write, size: size_e'(bus.req_size),
                     uns: bus.req_unsigned, addr: bus.req_addr};
        err_q   <= mis;
        rdata_q <= '0;
        cnt_q   <= '0;
        if (bus.req_write) wdata_q <= bus.req_wdata;
      end
      if (state_q == ST_RD) begin
        cnt_q <= cnt_q + 1'b1;
        // Last MemRead edge: read_data is valid, commit extract or merge.
        if (rd_last) begin
          if (req_q.write) wdata_q <= st_merge;
          else             rdata_q <= ld_ext;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (mis)                                         state_d = ST_RESP;
        else if (bus.req_write && bus.req_size == SZ_D)  state_d = ST_WR;
        else                                             state_d = ST_RD;
      end
      ST_RD:   if (rd_last) state_d = req_q.write ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    case (state_q)
      ST_IDLE: bus.req_ready = 1'b1;
      ST_RD:   bus.MemRead   = 1'b1;
      ST_WR:   bus.MemWrite  = 1'b1;
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  assign bus.addr       = {req_q.addr[63:3], 3'b000};
  assign bus.write_data = wdata_q;

`ifdef LSU_STATS_EN
  logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;
  logic        done;

  assign done = (state_q == ST_RESP) && bus.resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (done) begin
      if (err_q)            err_cnt_q <= sat_inc(err_cnt_q);
      else if (req_q.write) st_cnt_q  <= sat_inc(st_cnt_q);
      else                  ld_cnt_q  <= sat_inc(ld_cnt_q);
    end
  end

  assign bus.stat_ld  = ld_cnt_q;
  assign bus.stat_st  = st_cnt_q;
  assign bus.stat_err = err_cnt_q;
`else
  assign bus.stat_ld  = '0;
  assign bus.stat_st  = '0;
  assign bus.stat_err = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RD_LAT=0 and RD_LAT=1 instances run the same
// directed + random sequence against a byte-level reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        mem_clr;
  logic        req_valid_s, req_write_s, req_unsigned_s, resp_ready_s;
  logic [1:0]  req_size_s;
  logic [63:0] req_addr_s, req_wdata_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus0 ();
  load_store_unit_if bus1 ();

  load_store_unit #(.RD_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  load_store_unit #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.req_valid    = req_valid_s & ~sel;
  assign bus1.req_valid    = req_valid_s & sel;
  assign bus0.req_write    = req_write_s;
  assign bus1.req_write    = req_write_s;
  assign bus0.req_size     = req_size_s;
  assign bus1.req_size     = req_size_s;
  assign bus0.req_unsigned = req_unsigned_s;
  assign bus1.req_unsigned = req_unsigned_s;
  assign bus0.req_addr     = req_addr_s;
  assign bus1.req_addr     = req_addr_s;
  assign bus0.req_wdata    = req_wdata_s;
  assign bus1.req_wdata    = req_wdata_s;
  assign bus0.resp_ready   = resp_ready_s;
  assign bus1.resp_ready   = resp_ready_s;

  // Data_Memory models: 16 doublewords, sync write; combinational or 1-cycle read.
  logic [63:0] mem0 [16];
  logic [63:0] mem1 [16];
  logic [63:0] rd_q1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) begin mem0[i] <= '0; mem1[i] <= '0; end
    end else begin
      if (bus0.MemWrite) mem0[bus0.addr[6:3]] <= bus0.write_data;
      if (bus1.MemWrite) mem1[bus1.addr[6:3]] <= bus1.write_data;
    end
    if (bus1.MemRead) rd_q1 <= mem1[bus1.addr[6:3]];
  end
  assign bus0.read_data = mem0[bus0.addr[6:3]];
  assign bus1.read_data = rd_q1;

  wire        req_ready_m  = sel ? bus1.req_ready  : bus0.req_ready;
  wire        resp_valid_m = sel ? bus1.resp_valid : bus0.resp_valid;
  wire        resp_err_m   = sel ? bus1.resp_err   : bus0.resp_err;
  wire [63:0] resp_rdata_m = sel ? bus1.resp_rdata : bus0.resp_rdata;
  wire        mr_m         = sel ? bus1.MemRead    : bus0.MemRead;
  wire        mw_m         = sel ? bus1.MemWrite   : bus0.MemWrite;
  wire [63:0] addr_m       = sel ? bus1.addr       : bus0.addr;
  wire [63:0] wd_m         = sel ? bus1.write_data : bus0.write_data;
  wire [31:0] st_ld_m      = sel ? bus1.stat_ld    : bus0.stat_ld;
  wire [31:0] st_st_m      = sel ? bus1.stat_st    : bus0.stat_st;
  wire [31:0] st_err_m     = sel ? bus1.stat_err   : bus0.stat_err;

  function automatic logic [63:0] mem_rd(input int idx);
    return sel ? mem1[idx] : mem0[idx];
  endfunction

  // Strobe monitor on the selected instance.
  int          rd_cyc = 0, wr_cyc = 0, overlap = 0, addr_bad = 0;
  logic [63:0] exp_addr = '0;
  always @(negedge clk) begin
    if (mr_m) rd_cyc++;
    if (mw_m) wr_cyc++;
    if (mr_m && mw_m) overlap++;
    if ((mr_m || mw_m) && addr_m !== exp_addr) addr_bad++;
  end

  // Reference model: byte-addressed memory image and completion counts.
  logic [63:0] ref_mem [16];
  int n_ld, n_st, n_err;

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz,
                                             input bit uns);
    int n = 1 << sz;
    int off = int'(a[2:0]);
    logic [63:0] d = ref_mem[a[6:3]];
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (((d >> (8 * (off + i))) & 64'hFF) << (8 * i));
    if (!uns && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    int n = 1 << sz;
    int off = int'(a[2:0]);
    logic [63:0] d = ref_mem[a[6:3]];
    for (int i = 0; i < n; i++) d[8 * (off + i) +: 8] = wd[8 * i +: 8];
    ref_mem[a[6:3]] = d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (RD_LAT=%0d): observed %h expected %h", tag, sel, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef LSU_STATS_EN
    chk({tag, "_ld"},  64'(st_ld_m),  64'(n_ld));
    chk({tag, "_st"},  64'(st_st_m),  64'(n_st));
    chk({tag, "_err"}, 64'(st_err_m), 64'(n_err));
`else
    chk({tag, "_ld"},  64'(st_ld_m),  64'd0);
    chk({tag, "_st"},  64'(st_st_m),  64'd0);
    chk({tag, "_err"}, 64'(st_err_m), 64'd0);
`endif
  endtask

  task automatic xact(input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [63:0] a, input logic [63:0] wd, input int hold);
    int n = 1 << sz;
    bit exp_err = (int'(a[2:0]) % n) != 0;
    int rdl = sel ? 1 : 0;
    logic [63:0] exp_rd = '0;
    int exp_lat, exp_rdc, exp_wrc, lat, rd0, wr0, ab0;
    if (exp_err)      begin exp_lat = 1;       exp_rdc = 0;       exp_wrc = 0; end
    else if (!wr)     begin exp_lat = rdl + 2; exp_rdc = rdl + 1; exp_wrc = 0;
                            exp_rd = model_load(a, sz, uns); end
    else if (n == 8)  begin exp_lat = 2;       exp_rdc = 0;       exp_wrc = 1; end
    else              begin exp_lat = rdl + 3; exp_rdc = rdl + 1; exp_wrc = 1; end

    @(negedge clk);
    exp_addr = {a[63:3], 3'b000};
    req_write_s = wr; req_size_s = sz; req_unsigned_s = uns;
    req_addr_s = a;   req_wdata_s = wd; req_valid_s = 1'b1;
    resp_ready_s = (hold == 0);
    rd0 = rd_cyc; wr0 = wr_cyc; ab0 = addr_bad;
    chk("req_ready_idle", 64'(req_ready_m), 64'd1);
    @(posedge clk); #1;
    req_valid_s = 1'b0;
    lat = 1;
    while (!resp_valid_m && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_err", 64'(resp_err_m), 64'(exp_err));
    chk("resp_rdata", resp_rdata_m, exp_rd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(resp_valid_m), 64'd1);
      chk("hold_rdata", resp_rdata_m, exp_rd);
      chk("hold_ready", 64'(req_ready_m), 64'd0);
    end
    resp_ready_s = 1'b1;
    @(posedge clk); #1;
    chk("resp_done", 64'(resp_valid_m), 64'd0);
    chk("ready_back", 64'(req_ready_m), 64'd1);
    if (exp_err) n_err++;
    else if (wr) begin n_st++; model_store(a, sz, wd); end
    else n_ld++;
    chk("rd_cycles", 64'(rd_cyc - rd0), 64'(exp_rdc));
    chk("wr_pulses", 64'(wr_cyc - wr0), 64'(exp_wrc));
    chk("strobe_overlap", 64'(overlap), 64'd0);
    chk("strobe_addr", 64'(addr_bad - ab0), 64'd0);
    chk("mem_word", mem_rd(int'(a[6:3])), ref_mem[a[6:3]]);
  endtask

  task automatic run_all(input bit s);
    int n;
    sel = s;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid_s = 0; req_write_s = 0; req_size_s = 0; req_unsigned_s = 0;
    req_addr_s = '0; req_wdata_s = '0; resp_ready_s = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    n_ld = 0; n_st = 0; n_err = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_m), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid_m), 64'd0);
    chk("rst_resp_rdata", resp_rdata_m, 64'd0);
    chk("rst_resp_err", 64'(resp_err_m), 64'd0);
    chk("rst_memread", 64'(mr_m), 64'd0);
    chk("rst_memwrite", 64'(mw_m), 64'd0);
    chk("rst_addr", addr_m, 64'd0);
    chk("rst_write_data", wd_m, 64'd0);
    chk_stats("rst_stat");
    rst = 1'b0; mem_clr = 1'b0;

    // 1: dword store/load round trip
    xact(1, 2'b11, 0, 64'h0, 64'h1122334455667788, 0);
    xact(0, 2'b11, 0, 64'h0, 64'h0, 0);
    // 2: byte RMW in lane 3
    xact(1, 2'b00, 0, 64'h3, 64'h00000000000000AB, 0);
    chk("c2_mem0", mem_rd(0), 64'h11223344AB667788);
    xact(0, 2'b00, 1, 64'h3, 64'h0, 0);
    xact(0, 2'b00, 0, 64'h3, 64'h0, 0);
    // 3: upper word of doubleword 1, signed and unsigned
    xact(1, 2'b10, 0, 64'hC, 64'h0000000080000000, 0);
    xact(0, 2'b10, 0, 64'hC, 64'h0, 0);
    xact(0, 2'b10, 1, 64'hC, 64'h0, 0);
    chk("c3_mem1", mem_rd(1), 64'h8000000000000000);
    // 4: misaligned requests
    xact(0, 2'b01, 0, 64'h5, 64'h0, 0);
    xact(1, 2'b11, 0, 64'h4, 64'hDEADBEEFDEADBEEF, 0);
    chk_stats("c4_stat");
    // 5: response back-pressure
    xact(0, 2'b01, 0, 64'hE, 64'h0, 5);

    // 6: reset during the write cycle of a byte store
    @(negedge clk);
    exp_addr = 64'h10;
    req_write_s = 1; req_size_s = 2'b00; req_unsigned_s = 0;
    req_addr_s = 64'h11; req_wdata_s = 64'h5A; req_valid_s = 1'b1;
    @(posedge clk); #1;
    req_valid_s = 1'b0;
    n = 0;
    while (!mw_m && n < 10) begin @(posedge clk); #1; n++; end
    chk("c6_wr_reached", 64'(mw_m), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("c6_memwrite", 64'(mw_m), 64'd0);
    chk("c6_memread", 64'(mr_m), 64'd0);
    chk("c6_req_ready", 64'(req_ready_m), 64'd1);
    chk("c6_resp_valid", 64'(resp_valid_m), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_ld = 0; n_st = 0; n_err = 0;
    @(negedge clk);
    chk("c6_mem2", mem_rd(2), ref_mem[2]);

    // Random mix, including high address bits and misalignment.
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [63:0] a  = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) a = a | ({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FF80);
      if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
           {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    chk_stats("final_stat");
  endtask

  initial begin
    run_all(1'b0);
    run_all(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
